// File: rtl/spectrum_view_renderer.sv
// Double-buffered spectrum renderer: rotates raw panel timing into landscape
// coordinates and draws bar/line traces with grid in a 2-stage pipeline.
module spectrum_view_renderer #(
  parameter int NUM_TRACES = 2,
  parameter int BINS       = 256,
  parameter int VAL_W      = 9,
  parameter int BIN_SHIFT  = 1,
  parameter int RAW_H      = 480,
  parameter int RAW_V      = 800,
  parameter int ROTATE     = 1,
  parameter int GRID_Y     = 60
) (
  input  logic                    clk_pixel,
  input  logic                    rst_sync_n,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    active_i,
  input  logic                    hsync_i,
  input  logic                    vsync_i,
  input  logic                    mode,
  input  logic [NUM_TRACES-1:0]   trace_en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [1:0]              wr_trace,
  input  logic [$clog2(BINS)-1:0] wr_bin,
  input  logic [VAL_W-1:0]        wr_value,
  input  logic                    wr_commit,
  output logic [7:0]              red,
  output logic [7:0]              green,
  output logic [7:0]              blue,
  output logic                    hsync_o,
  output logic                    vsync_o,
  output logic                    active_o,
  output logic                    swap_done
);
  localparam int BW    = $clog2(BINS);
  localparam int DEPTH = 2 * NUM_TRACES * BINS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = 12;
  localparam logic [CW-1:0] LH_MAX = CW'(RAW_H - 1);
  localparam logic [CW-1:0] LW_MAX = CW'(RAW_V - 1);

  function automatic logic [23:0] trace_colour(input int t);
    case (t)
      0:       return 24'h00FF00;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      default: return 24'hFF00FF;
    endcase
  endfunction

  logic             front_q, front_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             swap_now, wr_fire;
  logic [AW-1:0]    wr_addr;
  logic [VAL_W-1:0] mem [DEPTH];

  logic [CW-1:0]    px, py, lx, ly;
  logic [BW-1:0]    bin;
  logic             oob, grid;
  logic [AW-1:0]    rd_addr [NUM_TRACES];

  logic [VAL_W-1:0] val_q [NUM_TRACES];
  logic [CW-1:0]    ly_q;
  logic             oob_q, grid_q, act1_q, hs1_q, vs1_q;

  logic [CW-1:0]         row, hgt;
  logic [NUM_TRACES-1:0] lit;
  logic [23:0]           rgb_d, rgb_q;
  logic                  act2_q, hs2_q, vs2_q;

  // Handshake: a write transfers on wr_valid && wr_ready; wr_ready drops
  // while a commit is waiting for end of frame, so the back bank is frozen.
  assign wr_ready = ~pend_q;
  assign wr_fire  = wr_valid && wr_ready && (int'(wr_trace) < NUM_TRACES);
  assign wr_addr  = AW'((int'(!front_q) * NUM_TRACES + int'(wr_trace)) * BINS + int'(wr_bin));

  always_comb begin
    front_d  = front_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    swap_now = pend_q && act1_q && !active_i && (pixel_y == 10'(RAW_V - 1));
    if (swap_now) begin
      front_d = ~front_q;
      pend_d  = wr_commit;
      done_d  = 1'b1;
    end else if (wr_commit) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      front_q <= front_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_fire) mem[wr_addr] <= wr_value;
  end

  assign px = CW'(pixel_x);
  assign py = CW'(pixel_y);

  always_comb begin
    lx = px;
    ly = py;
    if (ROTATE == 1) begin
      lx = py;
      ly = LH_MAX - px;
    end else if (ROTATE == 2) begin
      lx = LW_MAX - py;
      ly = px;
    end
  end

  assign bin  = BW'(lx >> BIN_SHIFT);
  assign oob  = (lx >> BIN_SHIFT) >= CW'(BINS);
  assign grid = ((ly % CW'(GRID_Y)) == '0) || (lx == '0);

  always_comb begin
    for (int t = 0; t < NUM_TRACES; t++)
      rd_addr[t] = AW'((int'(front_q) * NUM_TRACES + t) * BINS + int'(bin));
  end

  always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      for (int t = 0; t < NUM_TRACES; t++) val_q[t] <= '0;
      ly_q   <= '0;
      oob_q  <= 1'b0;
      grid_q <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      for (int t = 0; t < NUM_TRACES; t++) val_q[t] <= mem[rd_addr[t]];
      ly_q   <= ly;
      oob_q  <= oob;
      grid_q <= grid;
      act1_q <= active_i;
      hs1_q  <= hsync_i;
      vs1_q  <= vsync_i;
    end
  end

  // Rows below the landscape height (ly > LH-1) never light a trace.
  always_comb begin
    lit = '0;
    hgt = '0;
    row = LH_MAX - ly_q;
    for (int t = 0; t < NUM_TRACES; t++) begin
      hgt = (CW'(val_q[t]) > LH_MAX) ? LH_MAX : CW'(val_q[t]);
      if (trace_en[t] && !oob_q && (ly_q <= LH_MAX))
        lit[t] = mode ? (row == hgt) : (row <= hgt);
    end
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (act1_q && !oob_q) begin
      if (grid_q) rgb_d = 24'h404040;
      for (int t = NUM_TRACES - 1; t >= 0; t--)
        if (lit[t]) rgb_d = trace_colour(t);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rgb_q  <= 24'h000000;
      act2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      rgb_q  <= rgb_d;
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign active_o  = act2_q;
  assign hsync_o   = hs2_q;
  assign vsync_o   = vs2_q;
  assign swap_done = done_q;

endmodule

// File: tb/tb_spectrum_view_renderer.sv
// Bench for spectrum_view_renderer: one unrotated and one CCW instance share
// all inputs and are checked against a landscape-level reference model.
module tb_spectrum_view_renderer;
  localparam int NT = 2, BINS = 256, VAL_W = 10, BIN_SHIFT = 1;
  localparam int RAW_H = 480, RAW_V = 800, GRID_Y = 60;
  localparam logic [23:0] COLOURS [4] = '{24'h00FF00, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  logic             clk_pixel = 1'b0;
  logic             rst_sync_n = 1'b0;
  logic [9:0]       pixel_x = '0, pixel_y = '0;
  logic             active_i = 1'b1, hsync_i = 1'b0, vsync_i = 1'b0, mode = 1'b0;
  logic [NT-1:0]    trace_en = '1;
  logic             wr_valid = 1'b0, wr_commit = 1'b0;
  logic [1:0]       wr_trace = '0;
  logic [7:0]       wr_bin = '0;
  logic [VAL_W-1:0] wr_value = '0;
  logic             wr_ready [2], hsync_o [2], vsync_o [2], active_o [2], swap_done [2];
  logic [7:0]       red [2], green [2], blue [2];

  int n_assert = 0, n_fail = 0;
  int mem_m [2][NT][BINS];
  int front_m = 0, pend_m = 0;
  logic [2:0] exp_q [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    spectrum_view_renderer #(
      .NUM_TRACES(NT), .BINS(BINS), .VAL_W(VAL_W), .BIN_SHIFT(BIN_SHIFT),
      .RAW_H(RAW_H), .RAW_V(RAW_V), .ROTATE(g), .GRID_Y(GRID_Y)
    ) dut (
      .clk_pixel(clk_pixel), .rst_sync_n(rst_sync_n),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .active_i(active_i),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .mode(mode), .trace_en(trace_en),
      .wr_valid(wr_valid), .wr_ready(wr_ready[g]), .wr_trace(wr_trace),
      .wr_bin(wr_bin), .wr_value(wr_value), .wr_commit(wr_commit),
      .red(red[g]), .green(green[g]), .blue(blue[g]),
      .hsync_o(hsync_o[g]), .vsync_o(vsync_o[g]), .active_o(active_o[g]),
      .swap_done(swap_done[g])
    );
  end

  // Clock and watchdog
  initial forever #5 clk_pixel = ~clk_pixel;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, expv);
    end
  endtask

  function automatic logic [23:0] rgb(input int d);
    return {red[d], green[d], blue[d]};
  endfunction

  // Reference picture in landscape terms: d=0 unrotated, d=1 CCW
  function automatic logic [23:0] exp_rgb(input int d, input int x, input int y);
    int lx, ly, b, r, h;
    logic [23:0] c;
    lx = (d == 1) ? y : x;
    ly = (d == 1) ? RAW_H - 1 - x : y;
    b  = lx / (2 ** BIN_SHIFT);
    if (b >= BINS) return 24'h000000;
    c = (ly % GRID_Y == 0 || lx == 0) ? 24'h404040 : 24'h000000;
    r = RAW_H - 1 - ly;
    for (int t = NT - 1; t >= 0; t--) begin
      h = (mem_m[front_m][t][b] > RAW_H - 1) ? RAW_H - 1 : mem_m[front_m][t][b];
      if (trace_en[t] && r >= 0 && (mode ? (r == h) : (r <= h))) c = COLOURS[t];
    end
    return c;
  endfunction

  task automatic do_write(input int tr, input int b, input int v);
    wr_valid = 1'b1; wr_trace = 2'(tr); wr_bin = 8'(b); wr_value = VAL_W'(v);
    cyc();
    wr_valid = 1'b0;
    if (tr < NT) mem_m[1 - front_m][tr][b] = v;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    cyc();
    wr_commit = 1'b0;
    pend_m = 1;
  endtask

  task automatic end_frame(input bit commit_too);
    pixel_y = 10'(RAW_V - 1); active_i = 1'b1;
    cyc();
    active_i = 1'b0; wr_commit = commit_too;
    cyc();
    wr_commit = 1'b0; pixel_y = '0;
    for (int d = 0; d < 2; d++) chk("swap_done_pulse", d, swap_done[d], pend_m);
    if (pend_m != 0) begin
      front_m = 1 - front_m;
      pend_m  = commit_too;
    end else if (commit_too) begin
      pend_m = 1;
    end
    for (int d = 0; d < 2; d++) chk("wr_ready_after_frame", d, wr_ready[d], pend_m == 0);
    cyc();
    for (int d = 0; d < 2; d++) chk("swap_done_clear", d, swap_done[d], 0);
  endtask

  task automatic fill_back();
    for (int t = 0; t < NT; t++)
      for (int b = 0; b < BINS; b++) do_write(t, b, $urandom_range(0, 1023));
  endtask

  task automatic check_pix(input int x, input int y);
    pixel_x = 10'(x); pixel_y = 10'(y); active_i = 1'b1;
    cyc();
    cyc();
    for (int d = 0; d < 2; d++) chk("pixel_model", d, rgb(d), exp_rgb(d, x, y));
  endtask

  task automatic check_const(input string tag, input int x, input int y, input logic [23:0] c);
    check_pix(x, y);
    chk(tag, 0, rgb(0), c);
  endtask

  task automatic check_reset_outputs();
    for (int d = 0; d < 2; d++) begin
      chk("rst_rgb", d, rgb(d), 0);
      chk("rst_active_o", d, active_o[d], 0);
      chk("rst_hsync_o", d, hsync_o[d], 1);
      chk("rst_vsync_o", d, vsync_o[d], 1);
      chk("rst_swap_done", d, swap_done[d], 0);
      chk("rst_wr_ready", d, wr_ready[d], 1);
    end
  endtask

  initial begin
    int v, old, h9;
    logic [2:0] sig;
    // Reset state with inputs pulling the other way
    repeat (3) cyc();
    check_reset_outputs();
    hsync_i = 1'b1; vsync_i = 1'b1;
    rst_sync_n = 1'b1;
    cyc();

    // Populate both banks so nothing displayed is uninitialised
    fill_back(); commit(); end_frame(0);
    fill_back(); commit(); end_frame(0);

    // Bar mode, single trace
    do_write(0, 5, 100); commit(); end_frame(0);
    mode = 1'b0; trace_en = 2'b01;
    check_const("bar_top", 10, 379, 24'h00FF00);
    check_const("bar_bottom", 11, 479, 24'h00FF00);
    check_const("bar_above", 10, 378, 24'h000000);
    check_const("bar_above_c11", 11, 378, 24'h000000);
    check_const("grid_row", 10, 360, 24'h404040);

    // Line mode with clipping
    do_write(0, 5, 600); commit(); end_frame(0);
    mode = 1'b1;
    check_const("line_clip_top", 10, 0, 24'h00FF00);
    check_const("line_clip_next", 10, 1, 24'h000000);
    check_const("line_clip_bottom", 11, 479, 24'h000000);
    check_const("line_grid", 10, 60, 24'h404040);

    // Priority between overlapping traces
    do_write(0, 3, 50); do_write(1, 3, 200); commit(); end_frame(0);
    mode = 1'b0; trace_en = 2'b11;
    check_const("prio_green", 6, 429, 24'h00FF00);
    check_const("prio_yellow_lo", 6, 428, 24'hFFFF00);
    check_const("prio_yellow_hi", 7, 279, 24'hFFFF00);
    check_const("prio_above", 6, 278, 24'h000000);
    trace_en = 2'b01;
    check_const("prio_masked", 6, 428, 24'h000000);

    // Randomised frames and pixels
    for (int f = 0; f < 3; f++) begin
      fill_back(); commit(); end_frame(0);
      for (int k = 0; k < 60; k++) begin
        mode = 1'($urandom_range(0, 1));
        trace_en = NT'($urandom_range(0, 3));
        check_pix($urandom_range(0, RAW_H - 1), $urandom_range(0, RAW_V - 1));
      end
    end

    // Commit coincident with swap, and commit while already pending
    commit(); commit();
    end_frame(1);
    end_frame(0);
    end_frame(0);
    for (int k = 0; k < 10; k++) begin
      mode = 1'($urandom_range(0, 1)); trace_en = NT'($urandom_range(0, 3));
      check_pix($urandom_range(0, RAW_H - 1), $urandom_range(0, RAW_V - 1));
    end

    // Held write stalls until the swap, then lands in the new back bank
    mode = 1'b1; trace_en = 2'b01;
    old = mem_m[front_m][0][7];
    do v = $urandom_range(0, 479);
    while (v == old || v == mem_m[1 - front_m][0][7]);
    commit();
    wr_valid = 1'b1; wr_trace = 2'd0; wr_bin = 8'd7; wr_value = VAL_W'(v);
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 2; d++) chk("ready_low_pending", d, wr_ready[d], 0);
      cyc();
    end
    end_frame(0);
    wr_valid = 1'b0;
    mem_m[1 - front_m][0][7] = v;
    check_pix(14, RAW_H - 1 - v);
    check_pix(15, RAW_H - 1 - ((mem_m[front_m][0][7] > 479) ? 479 : mem_m[front_m][0][7]));
    commit(); end_frame(0);
    check_const("held_write_shown", 14, RAW_H - 1 - v, 24'h00FF00);

    // Writes to traces that do not exist are dropped
    do_write(2, 9, 123); do_write(3, 9, 321);
    h9 = (mem_m[front_m][0][9] > 479) ? 479 : mem_m[front_m][0][9];
    check_pix(18, RAW_H - 1 - h9);
    commit(); end_frame(0);
    for (int k = 0; k < 2; k++) begin
      h9 = (mem_m[front_m][0][9] > 479) ? 479 : mem_m[front_m][0][9];
      check_pix(18, RAW_H - 1 - h9);
      check_pix(19, $urandom_range(0, RAW_V - 1));
      commit(); end_frame(0);
    end

    // Sync/active latency with a scoreboard queue
    pixel_y = '0; pixel_x = '0;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 2) begin
        sig = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          chk("lat_active", d, active_o[d], sig[2]);
          chk("lat_hsync", d, hsync_o[d], sig[1]);
          chk("lat_vsync", d, vsync_o[d], sig[0]);
          if (!sig[2]) chk("blank_rgb", d, rgb(d), 0);
        end
      end
      active_i = 1'($urandom_range(0, 1));
      hsync_i  = 1'($urandom_range(0, 1));
      vsync_i  = 1'($urandom_range(0, 1));
      exp_q.push_back({active_i, hsync_i, vsync_i});
      cyc();
    end
    hsync_i = 1'b1; vsync_i = 1'b1;

    // Origin mapping under CCW rotation
    mode = 1'b0; trace_en = 2'b00;
    check_pix(0, 0);
    chk("ccw_origin_grid", 1, rgb(1), 24'h404040);
    trace_en = 2'b01;
    check_pix(0, 0);
    chk("ccw_origin_bar", 1, rgb(1), 24'h00FF00);

    // Reset while a swap is pending
    commit();
    pixel_y = 10'(RAW_V - 1); active_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    cyc();
    rst_sync_n = 1'b0;
    #2;
    check_reset_outputs();
    front_m = 0; pend_m = 0;
    cyc(); cyc();
    hsync_i = 1'b1; vsync_i = 1'b1;
    rst_sync_n = 1'b1;
    end_frame(0);
    for (int k = 0; k < 10; k++) begin
      mode = 1'($urandom_range(0, 1)); trace_en = NT'($urandom_range(0, 3));
      check_pix($urandom_range(0, RAW_H - 1), $urandom_range(0, RAW_V - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_view_renderer.md
SPECTRUM_VIEW_RENDERER -- requirements
Module: spectrum_view_renderer

Interface
REQ-001 Parameters, one per line as name, default, meaning:
  NUM_TRACES, 2, overlaid traces (1..4)
  BINS, 256, bins per trace (power of 2)
  VAL_W, 9, bin value width
  BIN_SHIFT, 1, landscape columns per bin = 2^BIN_SHIFT
  RAW_H, 480, raw timing active width
  RAW_V, 800, raw timing active height
  ROTATE, 1, 0 = none, 1 = CCW, 2 = CW
  GRID_Y, 60, horizontal grid pitch in landscape rows
REQ-002 Ports, one per line as name, direction, width, meaning:
  clk_pixel  in  1  pixel clock
  rst_sync_n  in  1  asynchronous active-low reset
  pixel_x  in  10  raw column
  pixel_y  in  10  raw row
  active_i  in  1  raw data enable
  hsync_i  in  1  raw hsync
  vsync_i  in  1  raw vsync
  mode  in  1  0 = bar, 1 = line
  trace_en  in  NUM_TRACES  per-trace draw enable
  wr_valid  in  1  write request
  wr_ready  out  1  write accepted
  wr_trace  in  2  target trace
  wr_bin  in  log2(BINS)  target bin
  wr_value  in  VAL_W  bin value
  wr_commit  in  1  pulse: publish back buffer
  red  out  8  pixel red
  green  out  8  pixel green
  blue  out  8  pixel blue
  hsync_o  out  1  hsync delayed 2
  vsync_o  out  1  vsync delayed 2
  active_o  out  1  active_i delayed 2
  swap_done  out  1  1-cycle pulse when a swap takes effect
REQ-003 Reset is rst_sync_n, asynchronous, active-low; clock is clk_pixel; all state is on clk_pixel.

Function
REQ-004 Storage shall be a double buffer of 2 x NUM_TRACES x BINS words of VAL_W bits; bank register front selects the displayed bank; writes go to bank ~front.
REQ-005 A write shall be accepted on a cycle with wr_valid && wr_ready; wr_trace >= NUM_TRACES shall be accepted and discarded.
REQ-006 wr_commit shall set swap_pending; wr_ready shall be 0 while swap_pending=1 and 1 otherwise.
REQ-007 The swap shall occur on the cycle where active_i falls 1->0 with pixel_y == RAW_V-1: front toggles, swap_pending clears, and swap_done pulses on the next cycle.
REQ-008 wr_commit coincident with the swap cycle shall leave swap_pending=1 for the following frame. wr_commit while already pending has no further effect.
REQ-009 Landscape coordinates (LW = RAW_V, LH = RAW_H):
  ROTATE=1: lx = pixel_y, ly = RAW_H-1-pixel_x
  ROTATE=2: lx = RAW_V-1-pixel_y, ly = pixel_x
  ROTATE=0: lx = pixel_x, ly = pixel_y
REQ-010 bin = lx >> BIN_SHIFT; columns with bin >= BINS shall render background.
REQ-011 Stage 1 shall register synchronous reads of all traces at bin from the front bank. Stage 2 shall register colour. Latency is 2 cycles; hsync/vsync/active shall pass through a matching 2-stage delay.
REQ-012 Height h = min(value, LH-1); row r = LH-1-ly is measured from the bottom.
  Bar mode: trace lit iff r <= h.
  Line mode: trace lit iff r == h.
  In both modes a trace is lit only if its trace_en bit is 1.
REQ-013 Colour priority shall be lowest-numbered lit trace:
  trace0 00FF00, trace1 FFFF00, trace2 00FFFF, trace3 FF00FF
  else grid 404040 when ly % GRID_Y == 0 or lx == 0
  else background 000000.
REQ-014 When active_o=0, rgb shall be 000000.
REQ-015 The front bank shall never be written; a swap request mid-frame shall not change the displayed bank before the end-of-frame condition in REQ-007.

Reset
REQ-016 On reset assertion, asynchronously:
  front=0, swap_pending=0, swap_done=0, wr_ready=1
  rgb=0, active_o=0, hsync_o=1, vsync_o=1
  delay and read pipeline registers cleared
REQ-017 RAM contents are not reset. Software shall write all enabled trace bins before a commit.
REQ-018 Reset asserted mid-frame or mid-swap shall discard the pending swap; after deassertion, output shall be black until the 2-cycle pipeline refills.

Verification
REQ-019 Scenario, bar mode: write trace0 bin5 = 100, commit, run to frame end, ROTATE=0, BIN_SHIFT=1, LH=480. Expect swap_done once; columns lx 10..11 are green for ly 379..479 and black/grid at ly 378.
REQ-020 Scenario, line and clipping: line mode, value 600, LH=480. Expect only ly=0 green in that bin's columns.
REQ-021 Scenario, priority: trace0 bin3 = 50 and trace1 bin3 = 200, bar mode. Expect green for r <= 50 and yellow for 51..200; trace_en=2'b01 removes the yellow.
REQ-022 Scenario, handshake: commit, then hold wr_valid. Expect wr_ready=0 until the swap cycle, then 1; the held write lands in the new back bank and the front bank stays unchanged.
REQ-023 Scenario, latency and rotation: ROTATE=1, toggle active_i. Expect active_o and sync outputs to follow exactly 2 cycles later, and raw pixel_x=0, pixel_y=0 to map to lx=0, ly=RAW_H-1.
REQ-024 Scenario, reset mid-swap: commit, then reset before frame end. Expect front=0, wr_ready=1, no swap_done, and outputs black with hsync_o=vsync_o=1.
